// File: rtl/mem_access_ctrl.sv
// MAR/MDR register pair and fixed-latency memory access sequencer for the SLC-3 datapath.
// A req pulse in IDLE runs one read or write against synchronous memory and ends with a one-cycle done.
module mem_access_ctrl #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]  mar_n, mdr_n;

  // Register loads are only honoured in IDLE; MDR otherwise changes only on the final read cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mar_n   = MAR;
    mdr_n   = MDR;
    case (state)
      IDLE: begin
        if (LD_MAR) mar_n = bus_in;
        if (LD_MDR) mdr_n = bus_in;
        if (req) begin
          state_n = we ? WR : RD;
          cnt_n   = CNT_W'(1);
        end
      end
      RD: begin
        if (cnt == CNT_W'(READ_LATENCY)) begin
          mdr_n   = mem_rdata;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WR: begin
        if (cnt == CNT_W'(WRITE_LATENCY)) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      MAR    <= '0;
      MDR    <= '0;
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      MAR    <= mar_n;
      MDR    <= mdr_n;
      mem_ce <= (state_n == RD) || (state_n == WR);
      mem_we <= (state_n == WR);
      busy   <= (state_n != IDLE);
      done   <= (state_n == DONE);
    end
  end

  assign mem_addr  = MAR;
  assign mem_wdata = MDR;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three latency variants share one stimulus stream and are each
// compared every cycle against a transaction-level model, plus directed scenario checks.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, ld_mar, ld_mdr, req, we;
  logic [15:0] bus, junk;

  logic [2:0][15:0] mar_o, mdr_o, addr_o, wdata_o, rdata;
  logic [2:0]       ce_o, we_o, busy_o, done_o;

  logic [15:0] env_mem [3][65536];
  logic [15:0] ref_mem [3][65536];

  int          rl [3] = '{2, 1, 3};
  int          wl [3] = '{1, 1, 2};
  bit          m_idle [3];
  bit          m_wr   [3];
  int          m_t0   [3];
  logic [15:0] m_mar  [3];
  logic [15:0] m_mdr  [3];

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign rdata[0] = ce_o[0] ? env_mem[0][addr_o[0]] : junk;
  assign rdata[1] = ce_o[1] ? env_mem[1][addr_o[1]] : junk;
  assign rdata[2] = ce_o[2] ? env_mem[2][addr_o[2]] : junk;

  mem_access_ctrl #(.DATA_W(16), .READ_LATENCY(2), .WRITE_LATENCY(1)) u0 (
    .Clk(clk), .Reset(rst), .bus_in(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .req(req), .we(we),
    .mem_rdata(rdata[0]), .MAR(mar_o[0]), .MDR(mdr_o[0]), .mem_addr(addr_o[0]),
    .mem_wdata(wdata_o[0]), .mem_ce(ce_o[0]), .mem_we(we_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  mem_access_ctrl #(.DATA_W(16), .READ_LATENCY(1), .WRITE_LATENCY(1)) u1 (
    .Clk(clk), .Reset(rst), .bus_in(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .req(req), .we(we),
    .mem_rdata(rdata[1]), .MAR(mar_o[1]), .MDR(mdr_o[1]), .mem_addr(addr_o[1]),
    .mem_wdata(wdata_o[1]), .mem_ce(ce_o[1]), .mem_we(we_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  mem_access_ctrl #(.DATA_W(16), .READ_LATENCY(3), .WRITE_LATENCY(2)) u2 (
    .Clk(clk), .Reset(rst), .bus_in(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .req(req), .we(we),
    .mem_rdata(rdata[2]), .MAR(mar_o[2]), .MDR(mdr_o[2]), .mem_addr(addr_o[2]),
    .mem_wdata(wdata_o[2]), .mem_ce(ce_o[2]), .mem_we(we_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access model: an accepted req at cycle t0 occupies cycles t0+1..t0+lat, done at t0+lat+1.
  task automatic model_step(input int i);
    int k, lat;
    if (rst) begin
      m_idle[i] = 1'b1;
      m_mar[i]  = '0;
      m_mdr[i]  = '0;
    end else if (m_idle[i]) begin
      if (ld_mar) m_mar[i] = bus;
      if (ld_mdr) m_mdr[i] = bus;
      if (req) begin
        m_idle[i] = 1'b0;
        m_t0[i]   = cyc;
        m_wr[i]   = we;
      end
    end else begin
      k   = cyc - m_t0[i];
      lat = m_wr[i] ? wl[i] : rl[i];
      if (k == lat) begin
        if (m_wr[i]) ref_mem[i][m_mar[i]] = m_mdr[i];
        else         m_mdr[i] = ref_mem[i][m_mar[i]];
      end
      if (k == lat + 1) m_idle[i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    int k, lat;
    bit e_ce, e_done;
    for (int i = 0; i < 3; i++) begin
      k      = cyc - m_t0[i];
      lat    = m_wr[i] ? wl[i] : rl[i];
      e_ce   = !m_idle[i] && (k >= 1) && (k <= lat);
      e_done = !m_idle[i] && (k == lat + 1);
      chk($sformatf("u%0d_mar@%0d", i, cyc),   mar_o[i],   m_mar[i]);
      chk($sformatf("u%0d_mdr@%0d", i, cyc),   mdr_o[i],   m_mdr[i]);
      chk($sformatf("u%0d_addr@%0d", i, cyc),  addr_o[i],  m_mar[i]);
      chk($sformatf("u%0d_wdata@%0d", i, cyc), wdata_o[i], m_mdr[i]);
      chk($sformatf("u%0d_ce@%0d", i, cyc),    16'(ce_o[i]),   16'(e_ce));
      chk($sformatf("u%0d_we@%0d", i, cyc),    16'(we_o[i]),   16'(e_ce && m_wr[i]));
      chk($sformatf("u%0d_busy@%0d", i, cyc),  16'(busy_o[i]), 16'(!m_idle[i]));
      chk($sformatf("u%0d_done@%0d", i, cyc),  16'(done_o[i]), 16'(e_done));
    end
  endtask

  // One clock: memory writes and model transition for the edge, then compare in the new cycle.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (ce_o[i] === 1'b1 && we_o[i] === 1'b1) env_mem[i][addr_o[i]] = wdata_o[i];
      model_step(i);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    junk = 16'($urandom);
    if (chk_en) compare_all();
  endtask

  task automatic clear_in();
    ld_mar = 1'b0; ld_mdr = 1'b0; req = 1'b0; we = 1'b0; rst = 1'b0;
  endtask

  task automatic wait_all_idle();
    int n = 0;
    while (busy_o !== 3'b000 && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 16'(busy_o), 16'(0));
  endtask

  task automatic load(input bit is_mar, input logic [15:0] v);
    bus = v; ld_mar = is_mar; ld_mdr = !is_mar;
    tick();
    clear_in();
  endtask

  initial begin
    int t, ndone;
    int dcyc [3];
    junk = 16'h0bad;
    bus  = '0;
    clear_in();
    for (int i = 0; i < 3; i++) begin
      m_idle[i] = 1'b1; m_wr[i] = 1'b0; m_t0[i] = 0; m_mar[i] = '0; m_mdr[i] = '0;
      for (int a = 0; a < 65536; a++) begin
        env_mem[i][a] = 16'(a * 7) ^ 16'h1357;
        ref_mem[i][a] = 16'(a * 7) ^ 16'h1357;
      end
      env_mem[i][16'h3000] = 16'hBEEF;
      ref_mem[i][16'h3000] = 16'hBEEF;
    end

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // Reset held two cycles in the middle of a read.
    load(1'b1, 16'h3000);
    req = 1'b1; tick(); clear_in();
    chk("rst_pre_ce", 16'(ce_o[0]), 16'(1));
    rst = 1'b1; tick(); tick(); clear_in();
    chk("rst_mar", mar_o[0], 16'h0000);
    chk("rst_mdr", mdr_o[0], 16'h0000);
    chk("rst_busy", 16'(busy_o), 16'(0));
    chk("rst_ce", 16'(ce_o), 16'(0));
    ndone = 0;
    for (int j = 0; j < 5; j++) begin
      ndone += int'(done_o[0]);
      tick();
    end
    chk("rst_no_done", 16'(ndone), 16'(0));

    // Plain read of 0xBEEF at 0x3000.
    load(1'b1, 16'h3000);
    req = 1'b1; tick(); clear_in();
    chk("rd_ce_t1", 16'(ce_o[0]), 16'(1));
    tick();
    chk("rd_ce_t2", 16'(ce_o[0]), 16'(1));
    tick();
    chk("rd_mdr_t3", mdr_o[0], 16'hBEEF);
    chk("rd_done_t3", 16'(done_o[0]), 16'(1));
    tick();
    chk("rd_busy_t4", 16'(busy_o[0]), 16'(0));
    chk("rd_done_t4", 16'(done_o[0]), 16'(0));
    wait_all_idle();

    // Write 0x1234 to 0x0042.
    load(1'b1, 16'h0042);
    load(1'b0, 16'h1234);
    req = 1'b1; we = 1'b1; tick(); clear_in();
    chk("wr_we_t1", 16'(we_o[0]), 16'(1));
    chk("wr_ce_t1", 16'(ce_o[0]), 16'(1));
    tick();
    chk("wr_done_t2", 16'(done_o[0]), 16'(1));
    chk("wr_mem", env_mem[0][16'h0042], 16'h1234);
    wait_all_idle();
    chk("wr_mem_u2", env_mem[2][16'h0042], 16'h1234);

    // Same-cycle MAR load and read request.
    bus = 16'hFFFF; ld_mar = 1'b1; req = 1'b1; tick(); clear_in();
    chk("sc_addr_1", addr_o[0], 16'hFFFF);
    chk("sc_ce_1", 16'(ce_o[0]), 16'(1));
    tick();
    chk("sc_addr_2", addr_o[0], 16'hFFFF);
    chk("sc_ce_2", 16'(ce_o[0]), 16'(1));
    wait_all_idle();

    // Loads and req during RD are ignored.
    load(1'b1, 16'h3000);
    req = 1'b1; tick(); clear_in();
    bus = 16'h5555; ld_mar = 1'b1; ld_mdr = 1'b1; req = 1'b1; we = 1'b1;
    tick(); clear_in();
    chk("ign_mar", mar_o[0], 16'h3000);
    ndone = int'(done_o[0]);
    for (int j = 0; j < 6; j++) begin
      tick();
      ndone += int'(done_o[0]);
    end
    chk("ign_one_done", 16'(ndone), 16'(1));
    chk("ign_mdr", mdr_o[0], 16'hBEEF);
    wait_all_idle();

    // Write then read back on the first IDLE cycle.
    load(1'b1, 16'h0010);
    load(1'b0, 16'hA5A5);
    req = 1'b1; we = 1'b1; tick(); clear_in();
    tick(); tick();
    chk("b2b_idle", 16'(busy_o[0]), 16'(0));
    req = 1'b1; tick(); clear_in();
    chk("b2b_busy", 16'(busy_o[0]), 16'(1));
    tick(); tick();
    chk("b2b_done", 16'(done_o[0]), 16'(1));
    chk("b2b_mdr", mdr_o[0], 16'hA5A5);
    wait_all_idle();

    // Read latency scaling across the three variants.
    t = cyc;
    dcyc = '{-1, -1, -1};
    req = 1'b1; tick(); clear_in();
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 3; i++) if (done_o[i] === 1'b1 && dcyc[i] < 0) dcyc[i] = cyc;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lat_u%0d", i), 16'(dcyc[i] - t), 16'(rl[i] + 1));
      chk($sformatf("lat_mdr_u%0d", i), mdr_o[i], 16'hA5A5);
    end

    // Random traffic against the model.
    for (int j = 0; j < 600; j++) begin
      case ($urandom_range(0, 4))
        0: bus = 16'h0010;
        1: bus = 16'h0042;
        2: bus = 16'hFFFF;
        3: bus = 16'($urandom_range(0, 15));
        default: bus = 16'($urandom);
      endcase
      ld_mar = ($urandom_range(0, 2) == 0);
      ld_mdr = ($urandom_range(0, 2) == 0);
      req    = ($urandom_range(0, 3) == 0);
      we     = 1'($urandom);
      rst    = ($urandom_range(0, 79) == 0);
      tick();
    end
    clear_in();
    wait_all_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
